// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues sequential word addresses to the instruction cache,
// buffers in-order returns and hands them to decode; redirects flush and drop stale returns.
module ifetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        i_halt,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_redirect_valid,
  input  logic        i_cache_ready,
  input  logic [19:0] i_cache_data,
  input  logic        i_cache_valid,
  input  logic        i_consumer_ready,
  output logic [15:0] o_cache_addr,
  output logic        o_cache_valid,
  output logic [19:0] o_instr,
  output logic [15:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]      pc;
  logic [15:0]      ent_pc   [DEPTH];
  logic [19:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_filled;
  logic [DEPTH-1:0] filled_next;
  logic [PW-1:0]    head, alloc, fill;
  logic [CW-1:0]    occ, pending, drop;

  logic          redirect, issue, pop, ret_fill, ret_drop;
  logic [CW-1:0] drop_next;

  // Stale returns still owed after a flush: the in-flight unfilled entries join the drop
  // count, minus a return landing this very cycle; saturated to [0, DEPTH].
  function automatic logic [CW-1:0] sat_drop(input logic [CW-1:0] d,
                                             input logic [CW-1:0] p,
                                             input logic          r);
    logic [CW:0] sum;
    sum = {1'b0, d} + {1'b0, p};
    if (r && (sum != '0)) sum = sum - 1'b1;
    if (sum > {1'b0, FULL}) sum = {1'b0, FULL};
    return sum[CW-1:0];
  endfunction

  assign redirect      = i_redirect_valid & ~i_halt;
  assign o_cache_addr  = pc;
  // Gated by arst_n so nothing is requested while reset is held.
  assign o_cache_valid = arst_n & ~i_halt & ~i_redirect_valid & (occ < FULL);
  assign issue         = o_cache_valid & i_cache_ready;

  assign o_instr_valid = ent_filled[head];
  assign o_instr       = ent_data[head];
  assign o_instr_pc    = ent_pc[head];
  assign o_busy        = (occ != '0) | (drop != '0);

  assign pop      = o_instr_valid & i_consumer_ready & ~i_halt & ~i_redirect_valid;
  assign ret_drop = i_cache_valid & ~i_halt & ~i_redirect_valid & (drop != '0);
  assign ret_fill = i_cache_valid & ~i_halt & ~i_redirect_valid & (drop == '0) & (pending != '0);
  assign drop_next = sat_drop(drop, pending, i_cache_valid);

  always_comb begin
    filled_next = ent_filled;
    if (issue)    filled_next[alloc] = 1'b0;
    if (pop)      filled_next[head]  = 1'b0;
    if (ret_fill) filled_next[fill]  = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc         <= RESET_PC;
      head       <= '0;
      alloc      <= '0;
      fill       <= '0;
      occ        <= '0;
      pending    <= '0;
      drop       <= '0;
      ent_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else if (!i_halt) begin
      if (redirect) begin
        pc         <= i_redirect_pc;
        head       <= '0;
        alloc      <= '0;
        fill       <= '0;
        occ        <= '0;
        pending    <= '0;
        drop       <= drop_next;
        ent_filled <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ent_pc[i]   <= '0;
          ent_data[i] <= '0;
        end
      end else begin
        if (issue) begin
          ent_pc[alloc] <= pc;
          alloc         <= alloc + 1'b1;
          pc            <= pc + 16'd1;
        end
        if (ret_fill) begin
          ent_data[fill] <= i_cache_data;
          fill           <= fill + 1'b1;
        end
        if (ret_drop) drop <= drop - 1'b1;
        if (pop)      head <= head + 1'b1;
        ent_filled <= filled_next;
        occ        <= occ + CW'(issue) - CW'(pop);
        pending    <= pending + CW'(issue) - CW'(ret_fill);
      end
    end
  end

endmodule
